skip_connection_feeder: RTL

- Operand fetch engine on the input side of the skip-connection adder: streams two fp16 feature-map regions (A = residual branch, B = shortcut) from two 64-bit SRAM banks.
- Presents them as 4-lane vectors with a single valid to the skip-connection unit.
- Counts the unit's result-valid pulses to declare the job complete.
- Sits between the layer controller (start/base/len) and the skip-connection datapath.

---
 rtl/skip_connection_feeder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/skip_connection_feeder.sv
// Operand fetch engine for the skip-connection adder: reads paired A/B words from two SRAM
// banks and presents them as 4-lane fp16 vectors. Optional build macro: SKIP_FEED_B_BYPASS_EN.
module skip_connection_feeder #(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LAT     = 2,
    parameter int LEN_BITS   = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [ADDR_BITS-1:0]           base_a_i,
    input  logic [ADDR_BITS-1:0]           base_b_i,
    input  logic [LEN_BITS-1:0]            len_i,
`ifdef SKIP_FEED_B_BYPASS_EN
    input  logic                           bypass_b_i,
`endif
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           sram_a_en_o,
    output logic                           sram_b_en_o,
    output logic [ADDR_BITS-1:0]           sram_a_addr_o,
    output logic [ADDR_BITS-1:0]           sram_b_addr_o,
    input  logic [4*DATA_WIDTH-1:0]        sram_a_rdata_i,
    input  logic [4*DATA_WIDTH-1:0]        sram_b_rdata_i,
    output logic                           op_valid_o,
    output logic [3:0][DATA_WIDTH-1:0]     op_a_o,
    output logic [3:0][DATA_WIDTH-1:0]     op_b_o,
    input  logic                           result_valid_i,
    output logic [1:0]                     state_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                state, state_next;
    logic [ADDR_BITS-1:0]  base_a_q, base_b_q;
    logic [LEN_BITS-1:0]   len_q, idx, ret_cnt, ret_next;
    logic [RD_LAT-1:0]     vld_pipe;
    logic                  bypass_q, bypass_in;
    logic                  accept, issue, ret_inc;

`ifdef SKIP_FEED_B_BYPASS_EN
    assign bypass_in = bypass_b_i;
`else
    assign bypass_in = 1'b0;
`endif

    assign accept        = (state == S_IDLE) && start_i;
    assign issue         = (state == S_ISSUE);
    assign sram_a_en_o   = issue;
    assign sram_b_en_o   = issue && !bypass_q;
    assign sram_a_addr_o = base_a_q + ADDR_BITS'(idx);
    assign sram_b_addr_o = base_b_q + ADDR_BITS'(idx);
    assign state_o       = state;

    // Result pulses only count while busy, and never past the job length.
    assign ret_inc  = busy_o && result_valid_i && (ret_cnt != len_q);
    assign ret_next = ret_inc ? ret_cnt + LEN_BITS'(1) : ret_cnt;

    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) state_next = (len_i == '0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                busy_o = 1'b1;
                if (idx == len_q - LEN_BITS'(1)) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy_o = 1'b1;
                if (ret_next == len_q) state_next = S_DONE;
            end
            S_DONE: begin
                done_o     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            base_a_q   <= '0;
            base_b_q   <= '0;
            len_q      <= '0;
            bypass_q   <= 1'b0;
            idx        <= '0;
            ret_cnt    <= '0;
            vld_pipe   <= '0;
            op_valid_o <= 1'b0;
            op_a_o     <= '0;
            op_b_o     <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                base_a_q <= base_a_i;
                base_b_q <= base_b_i;
                len_q    <= len_i;
                bypass_q <= bypass_in;
                idx      <= '0;
                ret_cnt  <= '0;
            end else begin
                if (issue) idx <= idx + LEN_BITS'(1);
                ret_cnt <= ret_next;
            end
            // Issue-enable travels alongside the SRAM latency; its tail marks valid rdata.
            vld_pipe   <= (vld_pipe << 1) | RD_LAT'(issue);
            op_valid_o <= vld_pipe[RD_LAT-1];
            if (vld_pipe[RD_LAT-1]) begin
                for (int l = 0; l < 4; l++) begin
                    op_a_o[l] <= sram_a_rdata_i[(4-l)*DATA_WIDTH-1 -: DATA_WIDTH];
                    op_b_o[l] <= bypass_q ? '0 : sram_b_rdata_i[(4-l)*DATA_WIDTH-1 -: DATA_WIDTH];
                end
            end
        end
    end

endmodule
